// File: rtl/spi_master_mode_if.sv
// Host-side control bus of spi_master_mode: transfer request, per-transfer settings and result.
// The master modport is the register logic issuing transfers; the slave modport is the SPI block.
interface spi_master_mode_if #(
   parameter int MAX_SIZE = 40,
   parameter int CS_SIZE  = 4,
   parameter int DIV_SIZE = 8
);
   localparam int LEN_W = $clog2(MAX_SIZE + 1);
   localparam int SEL_W = (CS_SIZE > 1) ? $clog2(CS_SIZE) : 1;

   logic                start_in;
   logic [MAX_SIZE-1:0] data_in;
   logic [LEN_W-1:0]    len_in;
   logic                cpol_in;
   logic                cpha_in;
   logic                lsb_first_in;
   logic [DIV_SIZE-1:0] clk_div_in;
   logic [SEL_W-1:0]    cs_select_in;
   logic                ready_out;
   logic                done_out;
   logic [MAX_SIZE-1:0] data_out;

   modport master (
      output start_in, data_in, len_in, cpol_in, cpha_in, lsb_first_in, clk_div_in, cs_select_in,
      input  ready_out, done_out, data_out
   );

   modport slave (
      input  start_in, data_in, len_in, cpol_in, cpha_in, lsb_first_in, clk_div_in, cs_select_in,
      output ready_out, done_out, data_out
   );
endinterface

// File: rtl/spi_master_mode.sv
// SPI master with run-time length, CPOL/CPHA, bit order, SCK rate and chip select per transfer.
// SCK comes from an edge counter in the internal_clk domain; every output is a register.
module spi_master_mode #(
   parameter int MAX_SIZE = 40,
   parameter int CS_SIZE  = 4,
   parameter int DIV_SIZE = 8
) (
   input  logic               internal_clk,
   input  logic               reset_n_in,
   spi_master_mode_if.slave   host,
   input  logic               miso_in,
   output logic               sck_out,
   output logic               mosi_out,
   output logic [CS_SIZE-1:0] cs_out_n
);
   localparam int LEN_W  = $clog2(MAX_SIZE + 1);
   localparam int SEL_W  = (CS_SIZE > 1) ? $clog2(CS_SIZE) : 1;
   localparam int SEL_N  = 2 ** SEL_W;
   localparam int EDGE_W = LEN_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

   state_t              state_q, state_d;
   logic [MAX_SIZE-1:0] tx_q, tx_d;
   logic [MAX_SIZE-1:0] rx_q, rx_d;
   logic [MAX_SIZE-1:0] dout_q, dout_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    tx_cnt_q, tx_cnt_d;
   logic                cpol_q, cpol_d;
   logic                cpha_q, cpha_d;
   logic                lsb_q, lsb_d;
   logic [DIV_SIZE-1:0] div_q, div_d;
   logic [DIV_SIZE-1:0] cnt_q, cnt_d;
   logic [EDGE_W-1:0]   edge_q, edge_d;
   logic [CS_SIZE-1:0]  cs_q, cs_d;
   logic                sck_q, sck_d;
   logic                mosi_q, mosi_d;
   logic                ready_q, ready_d;
   logic                done_q, done_d;

   logic                start_ok;
   logic                tick;
   logic                lead;
   logic                is_last;
   logic                do_sample;
   logic                do_drive;
   logic [EDGE_W-1:0]   next_edge;
   logic [EDGE_W-1:0]   last_edge;
   logic [LEN_W-1:0]    in_idx;
   logic [LEN_W-1:0]    tx_idx;
   logic [MAX_SIZE-1:0] rx_shift;
   logic [SEL_N-1:0]    sel_valid;

   // Select codes at or above CS_SIZE have no chip select behind them.
   genvar gi;
   generate
      for (gi = 0; gi < SEL_N; gi++) begin : g_sel_valid
         assign sel_valid[gi] = (gi < CS_SIZE);
      end
   endgenerate

   assign start_ok = host.start_in
                     && (host.len_in != '0)
                     && (host.len_in <= LEN_W'(MAX_SIZE))
                     && sel_valid[host.cs_select_in];

   // Odd edge numbers are leading edges; edge 2*len closes the transfer.
   assign tick      = (cnt_q == '0);
   assign next_edge = edge_q + EDGE_W'(1);
   assign last_edge = {len_q, 1'b0};
   assign lead      = next_edge[0];
   assign is_last   = (next_edge == last_edge);
   assign do_sample = cpha_q ^ lead;
   assign do_drive  = cpha_q ? lead : (~lead & ~is_last);

   assign in_idx   = host.lsb_first_in ? '0 : host.len_in - LEN_W'(1);
   assign tx_idx   = lsb_q ? tx_cnt_q : len_q - LEN_W'(1) - tx_cnt_q;
   assign rx_shift = lsb_q ? {miso_in, rx_q[MAX_SIZE-1:1]} : {rx_q[MAX_SIZE-2:0], miso_in};

   always_comb begin
      state_d  = state_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      dout_d   = dout_q;
      len_d    = len_q;
      tx_cnt_d = tx_cnt_q;
      cpol_d   = cpol_q;
      cpha_d   = cpha_q;
      lsb_d    = lsb_q;
      div_d    = div_q;
      cnt_d    = cnt_q;
      edge_d   = edge_q;
      cs_d     = cs_q;
      sck_d    = sck_q;
      mosi_d   = mosi_q;
      ready_d  = ready_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            sck_d   = host.cpol_in;
            if (start_ok) begin
               state_d  = S_SETUP;
               ready_d  = 1'b0;
               tx_d     = host.data_in;
               len_d    = host.len_in;
               cpol_d   = host.cpol_in;
               cpha_d   = host.cpha_in;
               lsb_d    = host.lsb_first_in;
               div_d    = host.clk_div_in;
               cnt_d    = host.clk_div_in;
               edge_d   = '0;
               rx_d     = '0;
               cs_d     = ~(CS_SIZE'(1) << host.cs_select_in);
               tx_cnt_d = '0;
               // CPHA=0 presents the first bit before any SCK edge.
               if (!host.cpha_in) begin
                  mosi_d   = host.data_in[in_idx];
                  tx_cnt_d = LEN_W'(1);
               end
            end
         end

         S_SETUP, S_SHIFT: begin
            if (tick) begin
               cnt_d   = div_q;
               sck_d   = ~sck_q;
               edge_d  = next_edge;
               state_d = is_last ? S_HOLD : S_SHIFT;
               if (do_sample) begin
                  rx_d = rx_shift;
               end
               if (do_drive) begin
                  mosi_d   = tx_q[tx_idx];
                  tx_cnt_d = tx_cnt_q + LEN_W'(1);
               end
            end else begin
               cnt_d = cnt_q - DIV_SIZE'(1);
            end
         end

         S_HOLD: begin
            if (tick) begin
               state_d = S_IDLE;
               cs_d    = '1;
               done_d  = 1'b1;
               ready_d = 1'b1;
               // LSB-first bits were shifted in from the top; realign to bit 0.
               dout_d  = lsb_q ? (rx_q >> (LEN_W'(MAX_SIZE) - len_q)) : rx_q;
            end else begin
               cnt_d = cnt_q - DIV_SIZE'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge internal_clk or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q  <= S_IDLE;
         tx_q     <= '0;
         rx_q     <= '0;
         dout_q   <= '0;
         len_q    <= '0;
         tx_cnt_q <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         lsb_q    <= 1'b0;
         div_q    <= '0;
         cnt_q    <= '0;
         edge_q   <= '0;
         cs_q     <= '1;
         sck_q    <= 1'b0;
         mosi_q   <= 1'b0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         dout_q   <= dout_d;
         len_q    <= len_d;
         tx_cnt_q <= tx_cnt_d;
         cpol_q   <= cpol_d;
         cpha_q   <= cpha_d;
         lsb_q    <= lsb_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         edge_q   <= edge_d;
         cs_q     <= cs_d;
         sck_q    <= sck_d;
         mosi_q   <= mosi_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
      end
   end

   assign host.ready_out = ready_q;
   assign host.done_out  = done_q;
   assign host.data_out  = dout_q;
   assign sck_out        = sck_q;
   assign mosi_out       = mosi_q;
   assign cs_out_n       = cs_q;
endmodule
